delta_frame_sched: RTL

- Frame-level sequencer for the absolute-difference delta datapath.
- Tracks pixel position in the incoming grayscale stream and decides, frame by frame, whether to capture a new base (reference) frame or compare against the stored one.
- Drives the base-frame buffer write/read strobes, the shared pixel address and the delta enable.
- Sits between the video input timing and the base-frame memory / delta stage.

---
 rtl/delta_frame_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/delta_frame_sched.sv
// Frame-level sequencer for the absolute-difference delta path: tracks pixel
// position and chooses per frame between capturing a new base frame and comparing.
module delta_frame_sched #(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int ADDR_WIDTH     = 19,
    parameter int REFRESH_FRAMES = 0
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic                  capture_req,
    output logic                  base_wr_en,
    output logic                  base_rd_en,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  delta_enable,
    output logic                  base_valid,
    output logic                  frame_done,
    output logic                  sync_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST        = ADDR_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE     = ADDR_WIDTH'(1);
    localparam logic [15:0]           REFRESH_CNT = 16'(REFRESH_FRAMES);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        CAPTURE  = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t                state_r, state_s, mode_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_s, pix_idx_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [15:0]           refresh_r, refresh_s;
    logic                  frame_open_r, frame_open_s;
    logic                  ovr_r, ovr_s;
    logic                  pending_r, pending_s;
    logic                  active_s;
    logic                  wr_r, wr_s;
    logic                  rd_r, rd_s;
    logic                  de_r, de_s;
    logic                  bv_r, bv_s;
    logic                  fd_r, fd_s;
    logic                  se_r, se_s;

    // Next-state and next-output decode for one presented pixel.
    always_comb begin
        state_s      = state_r;
        mode_s       = state_r;
        idx_s        = idx_r;
        pix_idx_s    = idx_r + IDX_ONE;
        addr_s       = addr_r;
        refresh_s    = refresh_r;
        frame_open_s = frame_open_r;
        ovr_s        = ovr_r;
        pending_s    = pending_r;
        active_s     = 1'b0;
        wr_s         = 1'b0;
        rd_s         = 1'b0;
        de_s         = de_r;
        bv_s         = bv_r;
        fd_s         = 1'b0;
        se_s         = 1'b0;

        if (state_r == RUN && capture_req) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end

        if (pix_valid) begin
            if (pix_sof) begin
                // frame_open_r is only set between a SOF and its LAST pixel
                pix_idx_s    = '0;
                active_s     = 1'b1;
                se_s         = frame_open_r;
                ovr_s        = 1'b0;
                frame_open_s = 1'b1;
                case (state_r)
                    RUN:     mode_s = (pending_r || capture_req) ? CAPTURE : RUN;
                    default: mode_s = CAPTURE;
                endcase
                if (mode_s == CAPTURE) begin
                    pending_s = 1'b0;
                end else begin
                    pending_s = pending_s;
                end
            end else if (frame_open_r) begin
                active_s = 1'b1;
            end else begin
                // Past the end of frame (or never synced): suppress, flag overrun once
                active_s = 1'b0;
                if (state_r != WAIT_SOF && !ovr_r) begin
                    se_s  = 1'b1;
                    ovr_s = 1'b1;
                end else begin
                    se_s = 1'b0;
                end
            end
        end else begin
            active_s = 1'b0;
        end

        if (active_s) begin
            idx_s   = pix_idx_s;
            addr_s  = pix_idx_s;
            state_s = mode_s;
            if (mode_s == CAPTURE) begin
                wr_s = 1'b1;
                de_s = 1'b0;
            end else begin
                rd_s = 1'b1;
                de_s = 1'b1;
            end
            if (pix_idx_s == LAST) begin
                fd_s         = 1'b1;
                frame_open_s = 1'b0;
                if (mode_s == CAPTURE) begin
                    bv_s      = 1'b1;
                    pending_s = 1'b0;
                    refresh_s = 16'd0;
                    state_s   = RUN;
                end else begin
                    refresh_s = refresh_r + 16'd1;
                    if (REFRESH_FRAMES > 0 && (refresh_r + 16'd1) == REFRESH_CNT) begin
                        pending_s = 1'b1;
                    end else begin
                        pending_s = pending_s;
                    end
                end
            end else begin
                fd_s = 1'b0;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r      <= WAIT_SOF;
            idx_r        <= '0;
            addr_r       <= '0;
            refresh_r    <= 16'd0;
            frame_open_r <= 1'b0;
            ovr_r        <= 1'b0;
            pending_r    <= 1'b0;
            wr_r         <= 1'b0;
            rd_r         <= 1'b0;
            de_r         <= 1'b0;
            bv_r         <= 1'b0;
            fd_r         <= 1'b0;
            se_r         <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            addr_r       <= addr_s;
            refresh_r    <= refresh_s;
            frame_open_r <= frame_open_s;
            ovr_r        <= ovr_s;
            pending_r    <= pending_s;
            wr_r         <= wr_s;
            rd_r         <= rd_s;
            de_r         <= de_s;
            bv_r         <= bv_s;
            fd_r         <= fd_s;
            se_r         <= se_s;
        end
    end

    assign base_wr_en   = wr_r;
    assign base_rd_en   = rd_r;
    assign base_addr    = addr_r;
    assign delta_enable = de_r;
    assign base_valid   = bv_r;
    assign frame_done   = fd_r;
    assign sync_err     = se_r;

endmodule
